// File: rtl/ahbl_sram_if_gen2.sv
// AHB-Lite slave bridging one AHB port to a synchronous single-port SRAM with byte-lane enables.
// Define AHBL_SRAM_ERR_RESP_EN to give oversize or misaligned transfers a two-cycle ERROR response.
module ahbl_sram_if_gen2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    HCLK,
  input  logic                    aresetn,
  input  logic                    HSEL,
  input  logic                    HREADYIN,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [31:0]             HADDR,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_AWIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int unsigned BW   = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(BW);

`ifdef AHBL_SRAM_ERR_RESP_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;
`endif

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic                  mem_ce_q, mem_ce_d;
  logic                  mem_we_q, mem_we_d;
  logic [BW-1:0]         mem_be_q, mem_be_d;
  logic [MEM_AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BW-1:0]         be_dec;
  logic [OFFW-1:0]       off;
  logic [2:0]            size_eff;
  logic                  accept;
  logic                  launch;
  logic                  unused_ok;

  assign accept   = HSEL & HREADYIN & HTRANS[1] & hreadyout_q;
  assign off      = HADDR[OFFW-1:0];
  assign size_eff = (HSIZE > 3'(OFFW)) ? 3'(OFFW) : HSIZE;

`ifdef AHBL_SRAM_ERR_RESP_EN
  logic illegal;
  assign illegal = (HSIZE > 3'(OFFW)) | (|(off & ~({OFFW{1'b1}} << HSIZE)));
`endif

  // A lane is enabled when it falls in the same size-aligned block as the
  // byte offset; this also truncates misaligned addresses to the boundary.
  always_comb begin
    be_dec = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      be_dec[i] = ((OFFW'(i) >> size_eff) == (off >> size_eff));
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = mem_addr_q;
    launch      = 1'b0;
    unique case (state_q)
      S_RD: begin
        if (cnt_q == 2'(RD_LATENCY)) begin
          launch = 1'b1;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          hreadyout_d = (cnt_d == 2'(RD_LATENCY));
        end
      end
`ifdef AHBL_SRAM_ERR_RESP_EN
      S_ERR1: begin
        state_d = S_ERR2;
        hresp_d = 1'b1;
      end
`endif
      default: launch = 1'b1;
    endcase

    // Every ready cycle doubles as the next address phase.
    if (launch) begin
      state_d = S_IDLE;
      if (accept) begin
`ifdef AHBL_SRAM_ERR_RESP_EN
        if (illegal) begin
          state_d     = S_ERR1;
          hreadyout_d = 1'b0;
          hresp_d     = 1'b1;
        end else
`endif
        begin
          mem_ce_d   = 1'b1;
          mem_addr_d = HADDR[MEM_AWIDTH+OFFW-1:OFFW];
          if (HWRITE) begin
            state_d  = S_WR;
            mem_we_d = 1'b1;
            mem_be_d = be_dec;
          end else begin
            state_d     = S_RD;
            cnt_d       = '0;
            hreadyout_d = 1'b0;
            mem_be_d    = '1;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = mem_rdata;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = HWDATA;
  assign unused_ok = ^{HTRANS[0], HADDR};

endmodule

// File: tb/tb_ahbl_sram_if_gen2.sv
// Bench for ahbl_sram_if_gen2: two instances (read latency 1 and 3) against a byte-level memory model.
module tb_ahbl_sram_if_gen2;

`ifdef AHBL_SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int LAT [2] = '{1, 3};

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  maddr;
    logic [31:0] rdata;
    logic        err;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [2];
  logic        hsel   [2];
  logic        hwrite [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [31:0] haddr  [2];
  logic [31:0] hwdata [2];

  logic        hro0, hro1, hresp0, hresp1, ce0, ce1, we0, we1;
  logic [31:0] hrdata0, hrdata1, mwdata0, mwdata1;
  logic [3:0]  be0, be1;
  logic [7:0]  maddr0, maddr1;

  logic        hro_a [2], hresp_a [2], ce_a [2], we_a [2];
  logic [31:0] hrdata_a [2], mwdata_a [2], mrd [2];
  logic [3:0]  be_a [2];
  logic [7:0]  maddr_a [2];

  logic [31:0] sram [2][256];
  logic [31:0] pipe [2][3];
  logic [7:0]  ref_mem [2][1024];

  op_t ops [$];
  int  total = 0;
  int  bad   = 0;
  int  cur_k = 0;

  ahbl_sram_if_gen2 #(.DATA_WIDTH(32), .MEM_AWIDTH(8), .RD_LATENCY(1)) u_dut_l1 (
    .HCLK(clk), .aresetn(rstn[0]), .HSEL(hsel[0]), .HREADYIN(hro0), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
    .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0), .mem_ce(ce0), .mem_we(we0),
    .mem_be(be0), .mem_addr(maddr0), .mem_wdata(mwdata0), .mem_rdata(mrd[0]));

  ahbl_sram_if_gen2 #(.DATA_WIDTH(32), .MEM_AWIDTH(8), .RD_LATENCY(3)) u_dut_l3 (
    .HCLK(clk), .aresetn(rstn[1]), .HSEL(hsel[1]), .HREADYIN(hro1), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
    .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrdata1), .mem_ce(ce1), .mem_we(we1),
    .mem_be(be1), .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_rdata(mrd[1]));

  always_comb begin
    hro_a[0] = hro0;       hro_a[1] = hro1;
    hresp_a[0] = hresp0;   hresp_a[1] = hresp1;
    ce_a[0] = ce0;         ce_a[1] = ce1;
    we_a[0] = we0;         we_a[1] = we1;
    be_a[0] = be0;         be_a[1] = be1;
    maddr_a[0] = maddr0;   maddr_a[1] = maddr1;
    hrdata_a[0] = hrdata0; hrdata_a[1] = hrdata1;
    mwdata_a[0] = mwdata0; mwdata_a[1] = mwdata1;
    mrd[0] = pipe[0][LAT[0]-1];
    mrd[1] = pipe[1][LAT[1]-1];
  end

  // SRAM macro model: byte-lane writes, read data after LAT edges.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ce_a[k] && we_a[k]) begin
        for (int b = 0; b < 4; b++)
          if (be_a[k][b]) sram[k][maddr_a[k]][8*b +: 8] <= mwdata_a[k][8*b +: 8];
      end
      if (ce_a[k] && !we_a[k]) pipe[k][0] <= sram[k][maddr_a[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, cur_k, $time, act, exp);
    end
  endtask

  // Reference: a transfer touches the 2^size-byte block containing addr
  // (clamped to the word); illegal ones touch nothing when errors are enabled.
  function automatic op_t model(input int k, input op_t op);
    op_t r;
    int  nb, base, w;
    r = op;
    nb = 1 << op.size;
    w = int'(op.addr >> 2);
    r.maddr = 8'(w);
    r.err = 1'b0;
    r.be = '0;
    r.rdata = '0;
    if (ERR_EN && (nb > 4 || (int'(op.addr[1:0]) % nb) != 0)) begin
      r.err = 1'b1;
      return r;
    end
    if (nb > 4) nb = 4;
    base = int'(op.addr[1:0]) / nb * nb;
    for (int b = base; b < base + nb; b++) begin
      r.be[b] = 1'b1;
      if (op.wr) ref_mem[k][w*4+b] = op.wdata[8*b +: 8];
    end
    for (int b = 0; b < 4; b++) r.rdata[8*b +: 8] = ref_mem[k][w*4+b];
    return r;
  endfunction

  // Pipelined master: issues ops back to back, checks every data-phase cycle.
  task automatic run_seq(input int k);
    int   cur, dp, dcyc, cyc, n, ew;
    logic rdy;
    op_t  o;
    cur_k = k;
    n = ops.size(); cur = 0; dp = -1; dcyc = 0; cyc = 0;
    while ((cur < n || dp >= 0) && cyc < 4000) begin
      cyc++;
      if (cur < n) begin
        hsel[k] = 1'b1; htrans[k] = 2'b10; hwrite[k] = ops[cur].wr;
        hsize[k] = ops[cur].size; haddr[k] = ops[cur].addr;
      end else begin
        hsel[k] = 1'b0; htrans[k] = 2'b00;
      end
      if (dp >= 0 && ops[dp].wr) hwdata[k] = ops[dp].wdata;
      else hwdata[k] = $urandom;
      @(negedge clk);
      rdy = hro_a[k];
      if (dp < 0) begin
        check("idle_ready", 64'(rdy), 64'd1);
        check("idle_ce", 64'(ce_a[k]), 64'd0);
        check("idle_be", 64'(be_a[k]), 64'd0);
        check("idle_resp", 64'(hresp_a[k]), 64'd0);
      end else begin
        o = ops[dp];
        ew = o.err ? 1 : (o.wr ? 0 : LAT[k]);
        if (o.err) begin
          check("err_resp", 64'(hresp_a[k]), 64'd1);
          check("err_ce", 64'(ce_a[k]), 64'd0);
          check("err_ready", 64'(rdy), 64'(dcyc != 0));
        end else begin
          check("resp", 64'(hresp_a[k]), 64'd0);
          check("ce", 64'(ce_a[k]), 64'(dcyc == 0));
          if (dcyc == 0) begin
            check("we", 64'(we_a[k]), 64'(o.wr));
            check("be", 64'(be_a[k]), o.wr ? 64'(o.be) : 64'hf);
            check("maddr", 64'(maddr_a[k]), 64'(o.maddr));
            if (o.wr) check("wdata", 64'(mwdata_a[k]), 64'(o.wdata));
          end else begin
            check("be_quiet", 64'(be_a[k]), 64'd0);
          end
        end
        if (rdy) begin
          check("waits", 64'(dcyc), 64'(ew));
          if (!o.wr && !o.err) check("rdata", 64'(hrdata_a[k]), 64'(o.rdata));
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        dp = (cur < n) ? cur : -1;
        if (cur < n) cur++;
        dcyc = 0;
      end else begin
        dcyc++;
      end
    end
    hsel[k] = 1'b0; htrans[k] = 2'b00;
    if (cur < n || dp >= 0) begin
      total++; bad++;
      $display("FAIL timeout inst=%0d got=%0d_ops_left want=0", k, n - cur);
    end
  endtask

  task automatic reset_midflight(input int k);
    op_t o;
    cur_k = k;
    hsel[k] = 1'b1; htrans[k] = 2'b10; hwrite[k] = 1'b0; hsize[k] = 3'd2; haddr[k] = 32'h10;
    @(posedge clk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'b00;
    @(negedge clk);
    check("rd_wait_ready", 64'(hro_a[k]), 64'd0);
    check("rd_wait_ce", 64'(ce_a[k]), 64'd1);
    #2 rstn[k] = 1'b0;
    #1;
    check("rst_ready", 64'(hro_a[k]), 64'd1);
    check("rst_ce", 64'(ce_a[k]), 64'd0);
    check("rst_resp", 64'(hresp_a[k]), 64'd0);
    check("rst_be", 64'(be_a[k]), 64'd0);
    check("rst_maddr", 64'(maddr_a[k]), 64'd0);
    @(negedge clk); rstn[k] = 1'b1;
    @(posedge clk); #1;
    hsel[k] = 1'b1; htrans[k] = 2'b10; hwrite[k] = 1'b1; hsize[k] = 3'd2; haddr[k] = 32'h20;
    @(posedge clk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwdata[k] = 32'hDEAD_BEEF;
    check("wr_ce", 64'(ce_a[k]), 64'd1);
    #2 rstn[k] = 1'b0;
    #1;
    check("rst_wr_ce", 64'(ce_a[k]), 64'd0);
    check("rst_wr_we", 64'(we_a[k]), 64'd0);
    @(negedge clk); rstn[k] = 1'b1;
    @(posedge clk); #1;
    ops.delete();
    o = '{1'b0, 3'd2, 32'h20, 32'h0, 4'h0, 8'h0, 32'h0, 1'b0};
    ops.push_back(model(k, o));
    o.addr = 32'h10;
    ops.push_back(model(k, o));
    run_seq(k);
  endtask

  task automatic random_test(input int k, input int n);
    op_t o;
    ops.delete();
    for (int i = 0; i < n; i++) begin
      o = '{1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 8'h0, 32'h0, 1'b0};
      o.wr    = 1'($urandom_range(0, 1));
      o.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      o.addr  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1 && o.size < 3'd3) o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      o.wdata = $urandom;
      ops.push_back(model(k, o));
    end
    run_seq(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t tbl [11];
    tbl[0]  = '{1'b1, 3'd0, 32'h3,  32'hA500_0000, 4'b1000, 8'd0, 32'h0,          1'b0};
    tbl[1]  = '{1'b0, 3'd2, 32'h0,  32'h0,         4'b1111, 8'd0, 32'hA500_0000,  1'b0};
    tbl[2]  = '{1'b1, 3'd2, 32'h0,  32'h1122_3344, 4'b1111, 8'd0, 32'h0,          1'b0};
    tbl[3]  = '{1'b1, 3'd2, 32'h4,  32'h5566_7788, 4'b1111, 8'd1, 32'h0,          1'b0};
    tbl[4]  = '{1'b0, 3'd2, 32'h0,  32'h0,         4'b1111, 8'd0, 32'h1122_3344,  1'b0};
    tbl[5]  = '{1'b0, 3'd2, 32'h10, 32'h0,         4'b1111, 8'd4, 32'h0,          1'b0};
    tbl[6]  = '{1'b1, 3'd1, 32'h6,  32'hBEEF_0000, 4'b1100, 8'd1, 32'h0,          1'b0};
    tbl[7]  = '{1'b0, 3'd2, 32'h4,  32'h0,         4'b1111, 8'd1, 32'hBEEF_7788,  1'b0};
`ifdef AHBL_SRAM_ERR_RESP_EN
    tbl[8]  = '{1'b1, 3'd1, 32'h1,  32'h0000_CAFE, 4'b0000, 8'd0, 32'h0,          1'b1};
    tbl[9]  = '{1'b0, 3'd3, 32'h8,  32'h0,         4'b0000, 8'd2, 32'h0,          1'b1};
    tbl[10] = '{1'b0, 3'd2, 32'h0,  32'h0,         4'b1111, 8'd0, 32'h1122_3344,  1'b0};
`else
    tbl[8]  = '{1'b1, 3'd1, 32'h1,  32'h0000_CAFE, 4'b0011, 8'd0, 32'h0,          1'b0};
    tbl[9]  = '{1'b1, 3'd3, 32'h8,  32'h0BAD_F00D, 4'b1111, 8'd2, 32'h0,          1'b0};
    tbl[10] = '{1'b0, 3'd2, 32'h0,  32'h0,         4'b1111, 8'd0, 32'h1122_CAFE,  1'b0};
`endif

    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; hsel[k] = 1'b0; hwrite[k] = 1'b0; htrans[k] = 2'b00;
      hsize[k] = 3'd0; haddr[k] = '0; hwdata[k] = '0;
      for (int i = 0; i < 256; i++) sram[k][i] = '0;
      for (int i = 0; i < 3; i++) pipe[k][i] = '0;
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_k = k;
      check("rst_hready", 64'(hro_a[k]), 64'd1);
      check("rst_hresp", 64'(hresp_a[k]), 64'd0);
      check("rst_ce0", 64'(ce_a[k]), 64'd0);
      check("rst_we0", 64'(we_a[k]), 64'd0);
      check("rst_be0", 64'(be_a[k]), 64'd0);
      check("rst_addr0", 64'(maddr_a[k]), 64'd0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cur_k = k;
        check("idle_hready", 64'(hro_a[k]), 64'd1);
        check("idle_hresp", 64'(hresp_a[k]), 64'd0);
        check("idle_ce0", 64'(ce_a[k]), 64'd0);
        check("idle_be0", 64'(be_a[k]), 64'd0);
      end
    end
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      ops.delete();
      for (int i = 0; i < 11; i++) begin
        void'(model(k, tbl[i]));
        ops.push_back(tbl[i]);
      end
      run_seq(k);
      reset_midflight(k);
      random_test(k, 80);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
